dmem_store_buffer: RTL and testbench

//  Sits between the out-of-order core's data-memory port and the data memory.

---
 rtl/dmem_store_buffer_pkg.sv | 26 ++
 rtl/dmem_store_buffer_if.sv | 37 +++
 rtl/dmem_store_buffer_fwd_match.sv | 28 ++
 rtl/dmem_store_buffer.sv | 124 ++++++++++++
 tb/tb_dmem_store_buffer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_store_buffer_pkg.sv
// rtl/dmem_store_buffer_pkg.sv - shared types and sizes for the data-memory store buffer
package store_buf_pkg;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int PTR_W  = $clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FENCE
    } sb_state_t;

    // Loads and stores are 8-byte transfers, so the low three address bits do not take part in a match.
    function automatic logic same_dword(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:3] == b[ADDR_W-1:3];
    endfunction

endpackage

// File: rtl/dmem_store_buffer_if.sv
// rtl/dmem_store_buffer_if.sv - core/memory side signal bundle of the store buffer
interface dmem_store_buffer_if;
    import store_buf_pkg::*;

    logic              st_valid_i;
    logic [ADDR_W-1:0] st_addr_i;
    logic [DATA_W-1:0] st_data_i;
    logic              st_ready_o;
    logic              ld_en_i;
    logic [ADDR_W-1:0] ld_addr_i;
    logic [DATA_W-1:0] ld_data_o;
    logic              ld_fwd_o;
    logic              fence_i;
    logic              fence_done_o;
    logic              mem_write_en_o;
    logic [ADDR_W-1:0] mem_addr_store_o;
    logic [DATA_W-1:0] mem_write_data_o;
    logic              mem_ready_i;
    logic              mem_read_en_o;
    logic [ADDR_W-1:0] mem_addr_load_o;
    logic [DATA_W-1:0] mem_read_data_i;

    modport slave (
        input  st_valid_i, st_addr_i, st_data_i, ld_en_i, ld_addr_i, fence_i,
               mem_ready_i, mem_read_data_i,
        output st_ready_o, ld_data_o, ld_fwd_o, fence_done_o, mem_write_en_o,
               mem_addr_store_o, mem_write_data_o, mem_read_en_o, mem_addr_load_o
    );

    modport master (
        output st_valid_i, st_addr_i, st_data_i, ld_en_i, ld_addr_i, fence_i,
               mem_ready_i, mem_read_data_i,
        input  st_ready_o, ld_data_o, ld_fwd_o, fence_done_o, mem_write_en_o,
               mem_addr_store_o, mem_write_data_o, mem_read_en_o, mem_addr_load_o
    );

endinterface

// File: rtl/dmem_store_buffer_fwd_match.sv
// rtl/dmem_store_buffer_fwd_match.sv - youngest-first address match over the store entries
module store_buf_fwd_match
    import store_buf_pkg::*;
(
    input  sb_entry_t         entries [DEPTH],
    input  logic [PTR_W-1:0]  tail,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data
);

    logic [PTR_W-1:0] idx;

    // Walk from the oldest slot (tail) up to tail-1 so the youngest valid match is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = DEPTH; i >= 1; i--) begin
            idx = tail - PTR_W'(i);
            if (entries[idx].valid && same_dword(entries[idx].addr, addr)) begin
                hit      = 1'b1;
                hit_data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - in-order committed-store queue with load forwarding and fence; option STORE_BUF_COALESCE_EN
module dmem_store_buffer
    import store_buf_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    dmem_store_buffer_if.slave bus
);

    sb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W:0]    count;
    sb_state_t         state;
    sb_state_t         state_nxt;

    logic              empty;
    logic              full;
    logic              coalesce;
    logic              push;
    logic              push_new;
    logic              pop;
    logic              hit;
    logic [DATA_W-1:0] hit_data;

    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(DEPTH));

`ifdef STORE_BUF_COALESCE_EN
    logic [PTR_W-1:0] youngest;
    assign youngest = tail - PTR_W'(1);
    // With two or more entries the youngest is not the head being presented, so it can absorb a repeat store.
    assign coalesce = (count > (PTR_W+1)'(1)) && entries[youngest].valid &&
                      (entries[youngest].addr == bus.st_addr_i);
`else
    assign coalesce = 1'b0;
`endif

    assign bus.st_ready_o = (~full | coalesce) & ~bus.fence_i;
    assign push           = bus.st_valid_i & bus.st_ready_o;
    assign push_new       = push & ~coalesce;
    assign pop            = ~empty & bus.mem_ready_i;

    assign bus.mem_write_en_o   = ~empty;
    assign bus.mem_addr_store_o = empty ? '0 : entries[head].addr;
    assign bus.mem_write_data_o = empty ? '0 : entries[head].data;

    store_buf_fwd_match u_fwd (
        .entries  (entries),
        .tail     (tail),
        .addr     (bus.ld_addr_i),
        .hit      (hit),
        .hit_data (hit_data)
    );

    assign bus.ld_fwd_o        = bus.ld_en_i & hit;
    assign bus.ld_data_o       = ~bus.ld_en_i ? '0 : (hit ? hit_data : bus.mem_read_data_i);
    assign bus.mem_read_en_o   = bus.ld_en_i & ~hit;
    assign bus.mem_addr_load_o = bus.ld_addr_i;
    assign bus.fence_done_o    = bus.fence_i & empty & (state != DRAIN);

    // Head/tail/count bookkeeping; a same-cycle push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop)
                head <= head + PTR_W'(1);
            if (push_new)
                tail <= tail + PTR_W'(1);
            count <= count + (PTR_W+1)'(push_new) - (PTR_W+1)'(pop);
        end
    end

    // Slot storage: popped head goes invalid, new store lands at tail, a coalesced store rewrites the youngest.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else begin
            if (pop)
                entries[head].valid <= 1'b0;
            if (push_new)
                entries[tail] <= '{valid: 1'b1, addr: bus.st_addr_i, data: bus.st_data_i};
`ifdef STORE_BUF_COALESCE_EN
            if (push && coalesce)
                entries[youngest].data <= bus.st_data_i;
`endif
        end
    end

    // Drain-mode state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: fence takes priority while draining; leaving a fence resumes draining if anything remains.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (push_new)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (bus.fence_i)
                    state_nxt = FENCE;
                else if (pop && !push_new && count == (PTR_W+1)'(1))
                    state_nxt = IDLE;
            end
            FENCE: begin
                if (!bus.fence_i)
                    state_nxt = empty ? IDLE : DRAIN;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - randomized and directed check of dmem_store_buffer against a queue model
module tb_dmem_store_buffer;

    localparam int MDEPTH = 4;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } st_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    st_t  q[$];
    logic fence_lvl;

    dmem_store_buffer_if bus();

    dmem_store_buffer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                         input logic le, input logic [63:0] la, input logic fe,
                         input logic mr, input logic [63:0] rd);
        bus.st_valid_i      = sv;
        bus.st_addr_i       = sa;
        bus.st_data_i       = sd;
        bus.ld_en_i         = le;
        bus.ld_addr_i       = la;
        bus.fence_i         = fe;
        bus.mem_ready_i     = mr;
        bus.mem_read_data_i = rd;
    endtask

    // One clock of stimulus: drive at the falling edge, check against the queue model, then advance the model at the rising edge.
    task automatic step(input logic sv, input logic [63:0] sa, input logic [63:0] sd,
                        input logic le, input logic [63:0] la, input logic fe,
                        input logic mr, input logic [63:0] rd);
        int          n;
        logic        coal;
        logic        rdy;
        logic        fwd;
        logic [63:0] fdata;
        st_t         t;
        @(negedge clk);
        drive(sv, sa, sd, le, la, fe, mr, rd);
        #1;
        n    = q.size();
        coal = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        if (n >= 2 && q[n-1].addr == sa)
            coal = 1'b1;
`endif
        rdy   = (n < MDEPTH || coal) && !fe;
        fwd   = 1'b0;
        fdata = '0;
        for (int i = 0; i < n; i++) begin
            if (q[i].addr[63:3] == la[63:3]) begin
                fwd   = 1'b1;
                fdata = q[i].data;
            end
        end
        chk("st_ready", 64'(bus.st_ready_o), 64'(rdy));
        chk("mem_wen", 64'(bus.mem_write_en_o), 64'(n > 0));
        chk("mem_waddr", bus.mem_addr_store_o, n > 0 ? q[0].addr : 64'd0);
        chk("mem_wdata", bus.mem_write_data_o, n > 0 ? q[0].data : 64'd0);
        chk("ld_fwd", 64'(bus.ld_fwd_o), 64'(le && fwd));
        chk("ld_data", bus.ld_data_o, !le ? 64'd0 : (fwd ? fdata : rd));
        chk("mem_ren", 64'(bus.mem_read_en_o), 64'(le && !fwd));
        chk("mem_raddr", bus.mem_addr_load_o, la);
        chk("fence_done", 64'(bus.fence_done_o), 64'(fe && n == 0));
        @(posedge clk);
        if (sv && rdy && coal) begin
            t      = q[n-1];
            t.data = sd;
            q[n-1] = t;
        end
        if (n > 0 && mr)
            void'(q.pop_front());
        if (sv && rdy && !coal) begin
            t.addr = sa;
            t.data = sd;
            q.push_back(t);
        end
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, mr, 64'd0);
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] d, input logic mr);
        step(1'b1, a, d, 1'b0, 64'd0, 1'b0, mr, 64'd0);
    endtask

    initial begin
        logic        sv;
        logic        le;
        logic        mr;
        logic [63:0] sa;
        logic [63:0] la;
        total     = 0;
        bad       = 0;
        fence_lvl = 1'b0;
        reset     = 1'b0;
        drive(1'b0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_st_ready", 64'(bus.st_ready_o), 64'd1);
        chk("rst_mem_wen", 64'(bus.mem_write_en_o), 64'd0);
        chk("rst_fence_done", 64'(bus.fence_done_o), 64'd0);
        reset = 1'b1;

        // single store drains the cycle after it is accepted
        push(64'h10, 64'hAA, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // fill, stall a fifth store, release one slot, drain in order
        for (int i = 0; i < 4; i++)
            push(64'h40 + 64'(i * 8), 64'h100 + 64'(i), 1'b0);
        push(64'h60, 64'h104, 1'b0);
        push(64'h60, 64'h104, 1'b1);
        push(64'h60, 64'h104, 1'b0);
        repeat (6) idle(1'b1);

        // youngest matching store forwarded
        push(64'h20, 64'h1, 1'b0);
        push(64'h20, 64'h2, 1'b0);
        step(1'b0, 64'd0, 64'd0, 1'b1, 64'h20, 1'b0, 1'b0, 64'hDEAD);
        step(1'b0, 64'd0, 64'd0, 1'b1, 64'h24, 1'b0, 1'b1, 64'hDEAD);
        // load with no match goes to memory
        step(1'b0, 64'd0, 64'd0, 1'b1, 64'h28, 1'b0, 1'b1, 64'h1234);
        idle(1'b1);

        // fence blocks stores and completes after the last pop
        for (int i = 0; i < 3; i++)
            push(64'h80 + 64'(i * 8), 64'h200 + 64'(i), 1'b0);
        repeat (5) step(1'b1, 64'h98, 64'h299, 1'b0, 64'd0, 1'b1, 1'b1, 64'd0);
        idle(1'b1);

        // reset mid-drain discards the queue immediately
        push(64'h50, 64'h301, 1'b0);
        push(64'h58, 64'h302, 1'b0);
        idle(1'b0);
        @(negedge clk);
        drive(1'b0, 64'd0, 64'd0, 1'b1, 64'h50, 1'b0, 1'b0, 64'h5555);
        reset = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(bus.mem_write_en_o), 64'd0);
        chk("mid_rst_waddr", bus.mem_addr_store_o, 64'd0);
        chk("mid_rst_wdata", bus.mem_write_data_o, 64'd0);
        chk("mid_rst_fwd", 64'(bus.ld_fwd_o), 64'd0);
        chk("mid_rst_ld", bus.ld_data_o, 64'h5555);
        chk("mid_rst_ready", 64'(bus.st_ready_o), 64'd1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        idle(1'b1);
        idle(1'b1);

`ifdef STORE_BUF_COALESCE_EN
        push(64'h30, 64'h1, 1'b0);
        push(64'h38, 64'h2, 1'b0);
        push(64'h38, 64'h3, 1'b0);
        push(64'h40, 64'h4, 1'b0);
        push(64'h48, 64'h5, 1'b0);
        push(64'h48, 64'h6, 1'b0);
        repeat (5) idle(1'b1);
`endif

        // randomized traffic over a small address pool so forwarding and fills happen often
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0)
                fence_lvl = ~fence_lvl;
            sv = ($urandom_range(0, 9) < 6);
            le = ($urandom_range(0, 1) == 1);
            mr = ($urandom_range(0, 9) < 6);
            sa = 64'h100 + 64'($urandom_range(0, 5) * 8);
            la = 64'h100 + 64'($urandom_range(0, 5) * 8) + 64'($urandom_range(0, 7));
            step(sv, sa, {$urandom, $urandom}, le, la, fence_lvl, mr, {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
